// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters with registered Hsync, Vsync, DE and start pulses.
// Latency: all outputs registered, updated one CLK after an EN=1 edge; backpressure: none, EN gates advance.
module vga_timing_gen #(
    parameter int HSIZE    = 640,
    parameter int HFP      = 16,
    parameter int HSW      = 96,
    parameter int HBP      = 48,
    parameter int VSIZE    = 480,
    parameter int VFP      = 10,
    parameter int VSW      = 2,
    parameter int VBP      = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    output logic        Hsync,
    output logic        Vsync,
    output logic        DE,
    output logic [13:0] hpos,
    output logic [13:0] vpos,
    output logic        line_start,
    output logic        frame_start
);

    localparam int HTOTAL = HSIZE + HFP + HSW + HBP;
    localparam int VTOTAL = VSIZE + VFP + VSW + VBP;

    localparam logic [13:0] H_LAST = 14'(HTOTAL - 1);
    localparam logic [13:0] H_ACT  = 14'(HSIZE);
    localparam logic [13:0] H_SS   = 14'(HSIZE + HFP);
    localparam logic [13:0] H_SE   = 14'(HSIZE + HFP + HSW - 1);
    localparam logic [13:0] V_LAST = 14'(VTOTAL - 1);
    localparam logic [13:0] V_ACT  = 14'(VSIZE);
    localparam logic [13:0] V_SS   = 14'(VSIZE + VFP);
    localparam logic [13:0] V_SE   = 14'(VSIZE + VFP + VSW - 1);

    localparam logic ACT_LVL = (SYNC_POL != 0);

    if (HTOTAL > 16383 || VTOTAL > 16383 ||
        HSIZE < 1 || HFP < 1 || HSW < 1 || HBP < 1 ||
        VSIZE < 1 || VFP < 1 || VSW < 1 || VBP < 1) begin : g_bad_params
        $error("vga_timing_gen: timing parameters out of range");
    end

    logic [13:0] h_nxt;
    logic [13:0] v_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        de_nxt;
    logic        hs_nxt;
    logic        vs_nxt;

    // Decode is done on the next-state counters so the registered syncs/DE
    // line up with the counter values presented in the same cycle.
    always_comb begin
        h_nxt  = hpos + 14'd1;
        v_nxt  = vpos;
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);
        if (h_wrap) begin
            h_nxt = 14'd0;
            v_nxt = v_wrap ? 14'd0 : vpos + 14'd1;
        end
        de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt = ((h_nxt >= H_SS) && (h_nxt <= H_SE)) ? ACT_LVL : ~ACT_LVL;
        vs_nxt = ((v_nxt >= V_SS) && (v_nxt <= V_SE)) ? ACT_LVL : ~ACT_LVL;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            DE          <= 1'b0;
            Hsync       <= ~ACT_LVL;
            Vsync       <= ~ACT_LVL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (EN) begin
                hpos        <= h_nxt;
                vpos        <= v_nxt;
                DE          <= de_nxt;
                Hsync       <= hs_nxt;
                Vsync       <= vs_nxt;
                line_start  <= h_wrap;
                frame_start <= h_wrap && v_wrap;
            end
        end
    end

endmodule
